// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
// Holds the R-type ALU op code, the funct codes the unit decodes and the
// controller state encoding.
package muldiv_pkg;

    localparam logic [1:0] ALU_OP_RTYPE = 2'b10;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMul  = 2'd1,
        StDiv  = 2'd2,
        StFix  = 2'd3
    } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiply/divide datapath.
// Ports:
//   is_div          : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc_hi, acc_lo  : current accumulator pair
//   operand         : multiplicand magnitude (mul) or divisor magnitude (div)
//   next_hi, next_lo: accumulator pair after this iteration
// Multiply: acc_lo holds the remaining multiplier bits; the product forms in
// {acc_hi, acc_lo}. Divide: acc_hi is the partial remainder, acc_lo shifts the
// dividend out at the top and the quotient bits in at the bottom.
module muldiv_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum     = {1'b0, acc_hi} + {1'b0, operand};
        shifted = {acc_hi, acc_lo[WIDTH-1]};
        // Only used when shifted >= operand, so the result fits in WIDTH bits.
        diff    = shifted[WIDTH-1:0] - operand;
        next_hi = acc_hi;
        next_lo = acc_lo;
        if (is_div) begin
            if (shifted >= {1'b0, operand}) begin
                next_hi = diff;
                next_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                next_hi = shifted[WIDTH-1:0];
                next_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else if (acc_lo[0]) begin
            {next_hi, next_lo} = {sum, acc_lo[WIDTH-1:1]};
        end else begin
            {next_hi, next_lo} = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit for a MIPS-style pipeline.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   start          : decode-stage instruction valid
//   alu_op, funct  : instruction decode (R-type when alu_op == 2'b10)
//   rs_val, rt_val : operands A and B
//   busy           : iterative operation in progress
//   stall          : pipeline must hold the current HI/LO instruction
//   done           : one-cycle pulse when HI/LO take a mult/div result
//   result         : mfhi/mflo read data
//   hi, lo         : architectural HI/LO registers
// Operations run on magnitudes for WIDTH cycles, then FIX spends two cycles:
// the first applies sign correction and divide special cases to the
// accumulators, the second commits them to HI/LO.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d, a_q, a_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             is_div_q, is_div_d, neg_q, neg_d, rem_neg_q, rem_neg_d;
    logic             div_zero_q, div_zero_d, fix_q, fix_d, done_q, done_d;

    logic rtype, dec_mfhi, dec_mthi, dec_mflo, dec_mtlo;
    logic dec_mult, dec_multu, dec_div, dec_divu, md_op, hilo_op;
    logic op_signed, a_neg, b_neg, step_div;
    logic [WIDTH-1:0] a_mag, b_mag, step_hi, step_lo;

    assign rtype     = (alu_op == ALU_OP_RTYPE);
    assign dec_mfhi  = rtype && (funct == FUNCT_MFHI);
    assign dec_mthi  = rtype && (funct == FUNCT_MTHI);
    assign dec_mflo  = rtype && (funct == FUNCT_MFLO);
    assign dec_mtlo  = rtype && (funct == FUNCT_MTLO);
    assign dec_mult  = rtype && (funct == FUNCT_MULT);
    assign dec_multu = rtype && (funct == FUNCT_MULTU);
    assign dec_div   = rtype && (funct == FUNCT_DIV);
    assign dec_divu  = rtype && (funct == FUNCT_DIVU);
    assign md_op     = dec_mult || dec_multu || dec_div || dec_divu;
    assign hilo_op   = md_op || dec_mfhi || dec_mthi || dec_mflo || dec_mtlo;

    assign op_signed = dec_mult || dec_div;
    assign a_neg     = op_signed && rs_val[WIDTH-1];
    assign b_neg     = op_signed && rt_val[WIDTH-1];
    assign a_mag     = a_neg ? -rs_val : rs_val;
    assign b_mag     = b_neg ? -rt_val : rt_val;

    assign busy     = (state_q != StIdle);
    assign stall    = busy && start && hilo_op;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign step_div = (state_q == StDiv);

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div  (step_div),
        .acc_hi  (acc_hi_q),
        .acc_lo  (acc_lo_q),
        .operand (opnd_q),
        .next_hi (step_hi),
        .next_lo (step_lo)
    );

    always_comb begin
        result = '0;
        if (dec_mfhi) begin
            result = hi_q;
        end else if (dec_mflo) begin
            result = lo_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opnd_d     = opnd_q;
        a_d        = a_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        is_div_d   = is_div_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        fix_d      = fix_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (dec_mthi) hi_d = rs_val;
                    if (dec_mtlo) lo_d = rs_val;
                    if (md_op) begin
                        is_div_d   = dec_div || dec_divu;
                        neg_d      = a_neg ^ b_neg;
                        rem_neg_d  = a_neg;
                        div_zero_d = (rt_val == '0);
                        a_d        = rs_val;
                        cnt_d      = '0;
                        acc_hi_d   = '0;
                        if (dec_div || dec_divu) begin
                            acc_lo_d = a_mag;
                            opnd_d   = b_mag;
                            state_d  = StDiv;
                        end else begin
                            acc_lo_d = b_mag;
                            opnd_d   = a_mag;
                            state_d  = StMul;
                        end
                    end
                end
            end
            StMul, StDiv: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = StFix;
                    fix_d   = 1'b0;
                end
            end
            StFix: begin
                if (!fix_q) begin
                    fix_d = 1'b1;
                    if (is_div_q) begin
                        if (neg_q) acc_lo_d = -acc_lo_q;
                        if (rem_neg_q) acc_hi_d = -acc_hi_q;
                        // Divide by zero overrides whatever the iterations produced.
                        if (div_zero_q) begin
                            acc_lo_d = '1;
                            acc_hi_d = a_q;
                        end
                    end else if (neg_q) begin
                        {acc_hi_d, acc_lo_d} = -{acc_hi_q, acc_lo_q};
                    end
                end else begin
                    hi_d    = acc_hi_q;
                    lo_d    = acc_lo_q;
                    done_d  = 1'b1;
                    fix_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_hi_q   <= '0;
            acc_lo_q   <= '0;
            opnd_q     <= '0;
            a_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            fix_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_hi_q   <= acc_hi_d;
            acc_lo_q   <= acc_lo_d;
            opnd_q     <= opnd_d;
            a_q        <= a_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            is_div_q   <= is_div_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            fix_q      <= fix_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH = 32): directed scenarios plus a
// randomized back-to-back sequence checked against a plain-arithmetic model.
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTLO  = 6'b010011;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   alu_op = 2'b00;
    logic [5:0]   funct = 6'd0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         busy, stall, done;
    logic [W-1:0] result, hi, lo;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    muldiv_unit #(
        .WIDTH (W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .alu_op (alu_op),
        .funct  (funct),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result),
        .hi     (hi),
        .lo     (lo)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: architectural result of one mult/div operation.
    task automatic model_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                            output logic [31:0] eh, output logic [31:0] el);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        sa = a;
        sb = b;
        eh = '0;
        el = '0;
        case (f)
            MULT: begin
                sp = longint'(sa) * longint'(sb);
                eh = sp[63:32];
                el = sp[31:0];
            end
            MULTU: begin
                up = {32'd0, a} * {32'd0, b};
                eh = up[63:32];
                el = up[31:0];
            end
            DIV: begin
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    el = 32'h8000_0000;
                    eh = 32'd0;
                end else begin
                    el = sa / sb;
                    eh = sa % sb;
                end
            end
            DIVU: begin
                if (b == 32'd0) begin
                    el = 32'hFFFF_FFFF;
                    eh = a;
                end else begin
                    el = a / b;
                    eh = a % b;
                end
            end
            default: ;
        endcase
    endtask

    // Issue one mult/div (called between a negedge and the next posedge) and
    // return at the negedge of the done cycle. lat counts edges after acceptance.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output bit busy_ok, output bit hold_ok);
        logic [31:0] h0, l0;
        h0 = hi;
        l0 = lo;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        lat = -1;
        start = 1'b1;
        alu_op = 2'b10;
        funct = f;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        funct = 6'd0;
        #1;
        if (!busy) busy_ok = 1'b0;
        if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
        for (int j = 1; j <= W + 10; j++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            if (done) begin
                lat = j;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        alu_op = 2'b10;
        funct = MULT;
        rs_val = 32'd3;
        rt_val = 32'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    endtask

    task automatic test_mult_directed();
        int lat;
        bit bok, hok;
        run_op(MULT, 32'd7, 32'hFFFF_FFFD, lat, bok, hok);
        n_checks++; if (lat !== W + 2) begin n_fail++; $display("FAIL mult_latency: got %0d want %0d", lat, W + 2); end
        n_checks++; if (!bok) begin n_fail++; $display("FAIL mult_busy: got gap want busy through k+%0d", W + 1); end
        n_checks++; if (!hok) begin n_fail++; $display("FAIL mult_hold: got HI/LO change want stable"); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_done: got %b want 0", busy); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse: got %b want 0", done); end
        run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bok, hok);
        n_checks++; if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        n_checks++; if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo: got %h want 1", lo); end
    endtask

    task automatic test_div_directed();
        int lat;
        bit bok, hok;
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, lat, bok, hok);
        n_checks++; if (lat !== W + 2) begin n_fail++; $display("FAIL div_latency: got %0d want %0d", lat, W + 2); end
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", hi); end
        run_op(DIVU, 32'd100, 32'd0, lat, bok, hok);
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu0_lo: got %h want ffffffff", lo); end
        n_checks++; if (hi !== 32'h0000_0064) begin n_fail++; $display("FAIL divu0_hi: got %h want 64", hi); end
        run_op(DIV, 32'hFFFF_FFF0, 32'd0, lat, bok, hok);
        n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div0_lo: got %h want ffffffff", lo); end
        n_checks++; if (hi !== 32'hFFFF_FFF0) begin n_fail++; $display("FAIL div0_hi: got %h want fffffff0", hi); end
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bok, hok);
        n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_lo: got %h want 80000000", lo); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL divovf_hi: got %h want 0", hi); end
    endtask

    task automatic test_mthi_mfhi();
        start = 1'b1;
        alu_op = 2'b10;
        funct = MTHI;
        rs_val = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        funct = MFHI;
        rs_val = 32'd0;
        #1;
        n_checks++; if (result !== 32'h1234_5678) begin n_fail++; $display("FAIL mfhi_result: got %h want 12345678", result); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mfhi_stall: got %b want 0", stall); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mthi_flags: got busy=%b done=%b want 0 0", busy, done); end
        funct = MTLO;
        rs_val = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        funct = MFLO;
        #1;
        n_checks++; if (result !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL mflo_result: got %h want cafef00d", result); end
        n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_keeps_hi: got %h want 12345678", hi); end
        funct = 6'b100000;
        #1;
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL nop_result: got %h want 0", result); end
        alu_op = 2'b00;
        funct = MFHI;
        #1;
        n_checks++; if (result !== 32'd0) begin n_fail++; $display("FAIL nonrtype_result: got %h want 0", result); end
        start = 1'b0;
    endtask

    task automatic test_stall_mflo();
        logic [31:0] a, b, eh, el, l0;
        int  stall_cycles;
        bit  stall_ok, hold_ok, saw_done;
        a = $urandom;
        b = $urandom;
        model_md(MULT, a, b, eh, el);
        l0 = lo;
        stall_cycles = 0;
        stall_ok = 1'b1;
        hold_ok = 1'b1;
        saw_done = 1'b0;
        start = 1'b1;
        alu_op = 2'b10;
        funct = MULT;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1;
        funct = MFLO;
        for (int j = 0; j < W + 10; j++) begin
            #1;
            if (done) begin
                saw_done = 1'b1;
                break;
            end
            if (stall) stall_cycles++;
            else stall_ok = 1'b0;
            if (lo !== l0) hold_ok = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        n_checks++; if (!saw_done) begin n_fail++; $display("FAIL stall_done: got no done want done"); end
        n_checks++; if (!stall_ok) begin n_fail++; $display("FAIL stall_held: got stall=0 early want 1"); end
        n_checks++; if (stall_cycles !== W - 3) begin n_fail++; $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, W - 3); end
        n_checks++; if (!hold_ok) begin n_fail++; $display("FAIL stall_lo_hold: got LO change want stable"); end
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %b want 0", stall); end
        n_checks++; if (result !== el) begin n_fail++; $display("FAIL stall_result: got %h want %h", result, el); end
        n_checks++; if (hi !== eh) begin n_fail++; $display("FAIL stall_hi: got %h want %h", hi, eh); end
        start = 1'b0;
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        start = 1'b1;
        alu_op = 2'b10;
        funct = MTHI;
        rs_val = 32'hA5A5_0001;
        @(posedge clk);
        @(negedge clk);
        funct = MTLO;
        rs_val = 32'h5A5A_0002;
        @(posedge clk);
        @(negedge clk);
        funct = DIV;
        rs_val = 32'd1000;
        rt_val = 32'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL abort_hi: got %h want 0", hi); end
        n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL abort_lo: got %h want 0", lo); end
        saw_done = 1'b0;
        for (int j = 0; j < W + 8; j++) begin
            if (done) saw_done = 1'b1;
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        n_checks++; if (saw_done) begin n_fail++; $display("FAIL abort_done: got done pulse want none"); end
    endtask

    task automatic test_random_back_to_back();
        logic [5:0]  f;
        logic [31:0] a, b, eh, el;
        int lat;
        bit bok, hok;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0: f = MULT;
                1: f = MULTU;
                2: f = DIV;
                default: f = DIVU;
            endcase
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: a = $urandom_range(0, 255);
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = -$urandom_range(1, 9);
                default: ;
            endcase
            model_md(f, a, b, eh, el);
            run_op(f, a, b, lat, bok, hok);
            n_checks++; if (lat !== W + 2) begin n_fail++; $display("FAIL rnd%0d_latency f=%h: got %0d want %0d", i, f, lat, W + 2); end
            n_checks++; if (!bok || !hok) begin n_fail++; $display("FAIL rnd%0d_busy_hold: got busy_ok=%b hold_ok=%b want 1 1", i, bok, hok); end
            n_checks++; if (hi !== eh) begin n_fail++; $display("FAIL rnd%0d_hi f=%h a=%h b=%h: got %h want %h", i, f, a, b, hi, eh); end
            n_checks++; if (lo !== el) begin n_fail++; $display("FAIL rnd%0d_lo f=%h a=%h b=%h: got %h want %h", i, f, a, b, lo, el); end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_mthi_mfhi();
        test_stall_mflo();
        test_reset_abort();
        test_random_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand/HI/LO width; legal values are even numbers 8..64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: the instruction in decode is valid this cycle.
REQ-005 SHALL have port alu_op, input, 2 bits: main-control ALU op; 2'b10 marks an R-type instruction.
REQ-006 SHALL have port funct, input, 6 bits: the R-type function field.
REQ-007 SHALL have port rs_val, input, WIDTH bits: operand A (dividend/multiplicand, mthi/mtlo source).
REQ-008 SHALL have port rt_val, input, WIDTH bits: operand B (divisor/multiplier).
REQ-009 SHALL have port busy, output, 1 bit: an iterative operation is in progress.
REQ-010 SHALL have port stall, output, 1 bit: the pipeline must hold the current instruction.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO take a mult/div result.
REQ-012 SHALL have port result, output, WIDTH bits: mfhi/mflo read data.
REQ-013 SHALL have port hi, output, WIDTH bits: HI register.
REQ-014 SHALL have port lo, output, WIDTH bits: LO register.

Function
REQ-015 SHALL decode, when alu_op==2'b10: mfhi 010000, mthi 010001, mflo 010010, mtlo 010011, mult 011000, multu 011001, div 011010, divu 011011; every other combination is a no-op for this block.
REQ-016 SHALL implement states IDLE, MUL, DIV, FIX; reset state is IDLE.
REQ-017 SHALL accept mult/multu/div/divu only in IDLE with start=1 and stall=0: operands are latched and the state moves to MUL or DIV.
REQ-018 SHALL run MUL and DIV for exactly WIDTH cycles, one bit per cycle (shift-add multiply; restoring divide on magnitudes).
REQ-019 SHALL go from MUL/DIV to FIX, which applies sign correction for signed ops, then return to IDLE.
REQ-020 SHALL apply signed-op sign rules: product sign = signA^signB; quotient sign = signA^signB; remainder sign = signA.
REQ-021 SHALL, for multiply, put the high WIDTH bits of the 2*WIDTH product in HI and the low WIDTH bits in LO.
REQ-022 SHALL, for divide, put the quotient in LO and the remainder in HI.
REQ-023 SHALL, on divide by zero (signed or unsigned), set LO = all ones and HI = rs_val; no trap.
REQ-024 SHALL, for signed most-negative / -1, set LO = most-negative and HI = 0.
REQ-025 SHALL meet this timing with acceptance at edge k:
 - busy=1 from edge k through edge k+WIDTH+1
 - at edge k+WIDTH+2: HI/LO hold the result, done=1 for one cycle, busy=0
REQ-026 SHALL keep HI/LO unchanged during MUL/DIV/FIX until the final update.
REQ-027 SHALL assert stall combinationally when busy=1 and start=1 with any of the eight decoded functs; a start in that case is not accepted.
REQ-028 SHALL, for mthi/mtlo in IDLE with start=1, write rs_val to HI/LO at the next edge, with no busy and no done.
REQ-029 SHALL drive result combinationally as HI for mfhi, LO for mflo, 0 otherwise; it is valid only when stall=0.
REQ-030 SHALL, when done and a new start coincide in the same cycle, accept the new operation, because the state is already IDLE.

Reset
REQ-031 SHALL, when reset=1 at an edge, set state=IDLE, clear HI, LO and the internal accumulators to 0, and set busy=0 and done=0; this aborts any operation in progress without writing HI/LO.
REQ-032 SHALL give reset priority over start.

Structure
REQ-033 SHALL place the funct codes, the alu_op R-type code and the state encoding in the shared package muldiv_pkg.
REQ-034 SHALL instantiate one sub-module, muldiv_step: combinational single-iteration shift-add/shift-subtract, WIDTH-parametrised.

Verification
REQ-035 SHALL cover this scenario (WIDTH=32): mult rs=7, rt=0xFFFFFFFD -> done at edge k+34, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-036 SHALL cover this scenario: multu 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-037 SHALL cover this scenario: div rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 100/0 -> LO=0xFFFFFFFF, HI=0x00000064.
REQ-038 SHALL cover this scenario: mflo issued 5 cycles after mult acceptance -> stall=1 until the done cycle, then result equals the new LO.
REQ-039 SHALL cover this scenario: reset asserted 10 cycles into a div -> next cycle busy=0, HI=LO=0, no done pulse.
REQ-040 SHALL cover this scenario: mthi rs=0x12345678, then mfhi the next cycle -> result=0x12345678, stall=0.
